// File: rtl/rng_bounded_sampler_if.sv
// rng_bounded_sampler_if: request/response channel bundle for the bounded sampler
//   req_valid/req_ready/req_bound : request channel (bound 0 = full 32-bit range)
//   out_valid/out_ready           : response handshake
//   out_data/out_tries/out_timeout: sample, draws used, fallback flag
interface rng_bounded_sampler_if #(parameter int TW = 5);
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_bound;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [TW-1:0] out_tries;
    logic          out_timeout;
    modport master (
        output req_valid, req_bound, out_ready,
        input  req_ready, out_valid, out_data, out_tries, out_timeout
    );
    modport slave (
        input  req_valid, req_bound, out_ready,
        output req_ready, out_valid, out_data, out_tries, out_timeout
    );
endinterface

// File: rtl/rng_bounded_sampler.sv
// rng_bounded_sampler: masked rejection sampling of a raw RNG stream into [0, bound)
//   clk, rst : clock, asynchronous active-high reset
//   rnd_in   : raw 32-bit generator word, one new word per cycle
//   bus      : slave side of the request/response channel bundle
module rng_bounded_sampler #(
    parameter int MAX_TRIES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 rnd_in,
    rng_bounded_sampler_if.slave        bus
);
    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   bound_q, bound_d;
    logic [31:0]   mask_q, mask_d;
    logic [TW-1:0] tries_q, tries_d;
    logic [31:0]   data_q, data_d;
    logic [TW-1:0] ntries_q, ntries_d;
    logic          timeout_q, timeout_d;

    logic [31:0]   m;
    logic [31:0]   cand;
    logic [TW-1:0] tries_nx;
    logic          hit;

    always_comb begin
        // Smear bound-1 down to the smallest all-ones mask covering it;
        // bound 0 wraps to all ones, giving the full range.
        m = bus.req_bound - 32'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        cand      = rnd_in & mask_q;
        tries_nx  = tries_q + TW'(1);
        hit       = (bound_q == 32'd0) || (cand < bound_q);
        state_d   = state_q;
        bound_d   = bound_q;
        mask_d    = mask_q;
        tries_d   = tries_q;
        data_d    = data_q;
        ntries_d  = ntries_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                bound_d = bus.req_bound;
                mask_d  = m;
                tries_d = '0;
                state_d = DRAW;
            end
            DRAW: if (hit) begin
                data_d    = cand;
                ntries_d  = tries_nx;
                timeout_d = 1'b0;
                state_d   = HOLD;
            end else if (tries_nx == TW'(MAX_TRIES)) begin
                // cand <= mask <= 2*bound-2, so one subtraction lands in range
                data_d    = cand - bound_q;
                ntries_d  = TW'(MAX_TRIES);
                timeout_d = 1'b1;
                state_d   = HOLD;
            end else begin
                tries_d = tries_nx;
            end
            HOLD: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bound_q   <= '0;
            mask_q    <= '0;
            tries_q   <= '0;
            data_q    <= '0;
            ntries_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bound_q   <= bound_d;
            mask_q    <= mask_d;
            tries_q   <= tries_d;
            data_q    <= data_d;
            ntries_q  <= ntries_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.out_valid   = (state_q == HOLD);
    assign bus.out_data    = data_q;
    assign bus.out_tries   = ntries_q;
    assign bus.out_timeout = timeout_q;
endmodule

// File: doc/rng_bounded_sampler.md
# rng_bounded_sampler

Downstream consumer of the free-running Taus88 generator: it turns the raw 32-bit word stream into unbiased uniform integers in [0, bound) by masked rejection sampling. A client issues a bound over a valid/ready request channel and receives one result over a valid/ready response channel. The result carries the number of draws used and a timeout flag. Each cycle the sampler is drawing, it consumes exactly one new generator word.

## Interface
- MAX_TRIES, 16: maximum draws per request, legal range 1..255.
- TW, $clog2(MAX_TRIES+1): width of out_tries (derived; not overridden).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rnd_in  in  32  raw generator word, new value every cycle.
- req_valid  in  1  request present.
- req_ready  out  1  sampler can accept a request.
- req_bound  in  32  exclusive upper bound; 0 means full 2^32 range.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  sample.
- out_tries  out  TW  draws used, 1..MAX_TRIES.
- out_timeout  out  1  MAX_TRIES rejections occurred; fallback value returned.

## Operation
- States:
  - IDLE: req_ready=1.
  - DRAW: req_ready=0, out_valid=0.
  - HOLD: out_valid=1, req_ready=0.
- Request acceptance:
  - A request is accepted in IDLE on req_valid && req_ready.
  - On acceptance, the block registers bound_r=req_bound, computes and registers mask_r, clears the try counter and moves to DRAW.
- Mask computation:
  - m = req_bound-1 (32-bit wrap), then smeared: m |= m>>1, >>2, >>4, >>8, >>16.
  - For bound 0, mask_r = 0xFFFFFFFF and every draw is accepted.
  - For bound 1, mask_r = 0 and the first draw yields 0.
- Draw in each DRAW cycle:
  - cand = rnd_in & mask_r; tries_next = tries+1.
  - Accept if bound_r==0 or cand < bound_r (unsigned). Register out_data=cand, out_tries=tries_next, out_timeout=0, then go to HOLD.
  - Reject with tries_next < MAX_TRIES: store tries_next and stay in DRAW.
  - Reject with tries_next == MAX_TRIES: register out_data=cand-bound_r, out_tries=MAX_TRIES, out_timeout=1, then go to HOLD.
  - The fallback value is always < bound because cand ≤ mask_r ≤ 2·bound_r-2.
- HOLD:
  - out_data, out_tries and out_timeout hold stable while out_valid && !out_ready.
  - When out_ready=1, go to IDLE.
  - rnd_in is ignored in IDLE and HOLD.
- Each accepted request produces exactly one response. No request queueing.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, so req_ready=1.
  - out_valid=0, out_data=0, out_tries=0, out_timeout=0.
  - bound_r=0, mask_r=0, tries=0.
- Reset mid-operation:
  - Asserting rst in DRAW or HOLD aborts the request with no response.
  - The block is in IDLE in the first cycle after rst deasserts.
- Request handshake at the edge ending cycle T:
  - The first draw uses rnd_in during cycle T+1.
  - Accept on draw k means out_valid rises in cycle T+1+k.
  - Minimum latency is 2 cycles from request handshake to out_valid.
- Response handshake at the edge ending cycle H: req_ready=1 in cycle H+1.
  - Back-to-back throughput is therefore at most one request per 3 cycles.
- Output drive:
  - req_ready and out_valid are decoded purely from registered state.
  - No combinational path from req_valid or out_ready to any output.
- Simultaneous req_valid in HOLD: ignored; the request must be held until req_ready.

## Test plan
- Reset:
  - Assert rst with stimulus on all inputs: req_ready=1, out_valid=0, out_data=0, out_tries=0 immediately, with no clock edge needed.
- Rejection then accept:
  - Input: bound=10, so mask 0xF. rnd_in = 0x0000000E in T+1, then 0x12345673 in T+2.
  - Required: out_valid in T+3, out_data=3, out_tries=2, out_timeout=0.
- Full range:
  - Input: bound=0, rnd_in=0xDEADBEEF in T+1.
  - Required: out_valid in T+2, out_data=0xDEADBEEF, out_tries=1.
  - Also check bound=1 with any rnd_in: out_data=0, out_tries=1.
- Timeout:
  - Input: MAX_TRIES=4, bound=5 (mask 7), rnd_in held at 0x00000007.
  - Required: out_valid in T+5, out_data=2, out_tries=4, out_timeout=1.
- Backpressure:
  - Input: out_ready held low 5 cycles in HOLD while rnd_in changes and req_valid=1.
  - Required: outputs stable and req_ready=0 throughout.
  - Then out_ready=1 at edge H: req_ready=1 in H+1, and the next request is accepted.
- Reset mid-DRAW:
  - Input: bound=5 with rnd_in=7 continuously; pulse rst in the 2nd DRAW cycle.
  - Required: no out_valid ever, and req_ready=1 after release.
  - A fresh request then completes normally.
